// File: rtl/display_scan_mux.sv
// Time-multiplexed hex scanner for a common-anode 7-segment display with a
// frame-aligned valid/ready word buffer. Define LZB_EN for leading-zero blanking.
module display_scan_mux #(
  parameter int NDIG = 8,
  parameter int DIV  = 50000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NDIG*4-1:0] iData,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iBlank,
  output logic [3:0]        Nibble,
  output logic [NDIG-1:0]   oDigEn,
  output logic              oFrame
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(NDIG);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NDIG*4-1:0] disp_q, disp_d;
  logic [NDIG*4-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [3:0]        nibble_q, nibble_d;
  logic [NDIG-1:0]   dig_en_q, dig_en_d;
  logic              frame_q, frame_d;

  logic              tick, boundary, swap, capture, digit_on;
  logic [NDIG*4-1:0] src;

  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    boundary = tick && (idx_q == '0);
    swap     = boundary && pend_full_q;
    capture  = iValid && !pend_full_q;
    // Swapping word is forwarded so digit 0 of the new frame already shows it
    src      = swap ? pend_q : disp_q;

    presc_d     = tick ? '0 : presc_q + PW'(1);
    idx_d       = idx_q;
    nibble_d    = nibble_q;
    dig_en_d    = dig_en_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    frame_d     = boundary;
    digit_on    = 1'b1;

`ifdef LZB_EN
    // Lit if this digit or any more significant one is nonzero; digit 0 always lit
    digit_on = (idx_q == '0) || ((src >> {idx_q, 2'b00}) != '0);
`endif

    if (tick) begin
      idx_d    = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      nibble_d = src[{idx_q, 2'b00} +: 4];
      dig_en_d = (iBlank || !digit_on) ? '1 : ~(NDIG'(1) << idx_q);
    end

    if (swap) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end

    if (capture) begin
      pend_d      = iData;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      nibble_q    <= '0;
      dig_en_q    <= '1;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      nibble_q    <= nibble_d;
      dig_en_q    <= dig_en_d;
      frame_q     <= frame_d;
    end
  end

  assign oReady = !pend_full_q;
  assign Nibble = nibble_q;
  assign oDigEn = dig_en_q;
  assign oFrame = frame_q;

endmodule
